ex_result_stage: RTL and testbench

- Execute-stage result/branch-resolution stage, directly downstream of the 32-bit ALU.
- Consumes ALU result and flags (Out, Zero, Ofl, carry-out) plus instruction side-band.
- Resolves conditional branches and jumps from the flags, selects the writeback value, and registers everything into the EX/MEM boundary behind a valid/ready handshake.
- Emits a one-cycle redirect to fetch on a taken branch/jump.

---
 rtl/ex_result_stage_pkg.sv | 14 +
 rtl/ex_result_stage_br_cond.sv | 32 +++
 rtl/ex_result_stage.sv | 170 +++++++++++++++++
 tb/tb_ex_result_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_result_stage_pkg.sv
// Shared constants for the EX result stage: branch funct3 codes and default entry field widths.
package ex_result_stage_pkg;

    localparam int EX_DATA_W = 32;
    localparam int EX_REG_W  = 5;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

endpackage

// File: rtl/ex_result_stage_br_cond.sv
// Branch condition decode from ALU flags of A-B; codes 010/011 are never taken.
module br_cond
    import ex_result_stage_pkg::*;
#(
    parameter int DATA_W = EX_DATA_W
) (
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    input  logic              alu_ofl,
    input  logic              alu_cout,
    input  logic [2:0]        br_funct3,
    output logic              cond
);

    logic lt_s;

    assign lt_s = alu_out[DATA_W-1] ^ alu_ofl;

    always_comb begin
        cond = 1'b0;
        case (br_funct3)
            BR_BEQ:  cond = alu_zero;
            BR_BNE:  cond = ~alu_zero;
            BR_BLT:  cond = lt_s;
            BR_BGE:  cond = ~lt_s;
            BR_BLTU: cond = ~alu_cout;
            BR_BGEU: cond = alu_cout;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_result_stage.sv
// EX/MEM boundary register with branch resolution and one-cycle fetch redirect.
// Define EX_SKID_BUF_EN for a two-entry (main + skid) buffer with a registered in_ready.
module ex_result_stage
    import ex_result_stage_pkg::*;
#(
    parameter int DATA_W = EX_DATA_W,
    parameter int REG_W  = EX_REG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    input  logic              alu_ofl,
    input  logic              alu_cout,
    input  logic              br_en,
    input  logic              jump,
    input  logic [2:0]        br_funct3,
    input  logic [DATA_W-1:0] br_target,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [REG_W-1:0]  rd,
    input  logic              rd_we,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [DATA_W-1:0] store_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_rd_we,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    output logic              redirect,
    output logic [DATA_W-1:0] redirect_pc
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] store_data;
        logic [REG_W-1:0]  rd;
        logic              rd_we;
        logic              mem_rd;
        logic              mem_wr;
    } entry_t;

    logic              cond, taken, accept;
    entry_t            in_ent;
    entry_t            main_q, main_d;
    logic              main_vld_q, main_vld_d;
    logic              redirect_q, redirect_d;
    logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;

    br_cond #(.DATA_W(DATA_W)) u_br_cond (
        .alu_out   (alu_out),
        .alu_zero  (alu_zero),
        .alu_ofl   (alu_ofl),
        .alu_cout  (alu_cout),
        .br_funct3 (br_funct3),
        .cond      (cond)
    );

    // jump dominates br_en, so a JAL/JALR flagged as a branch still writes its link
    assign taken  = jump | (br_en & cond);
    assign accept = in_valid & in_ready;

    always_comb begin
        in_ent            = '0;
        in_ent.result     = jump ? pc_plus4 : alu_out;
        in_ent.store_data = store_data;
        in_ent.rd         = rd;
        in_ent.rd_we      = rd_we & ~(br_en & ~jump);
        in_ent.mem_rd     = mem_rd;
        in_ent.mem_wr     = mem_wr;
    end

    always_comb begin
        redirect_d    = accept & taken & ~flush;
        redirect_pc_d = redirect_pc_q;
        if (accept & taken & ~flush) redirect_pc_d = br_target;
    end

`ifdef EX_SKID_BUF_EN
    entry_t skid_q, skid_d;
    logic   skid_vld_q, skid_vld_d;

    assign in_ready = ~skid_vld_q & ~redirect_q;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (main_vld_q & out_ready) begin
            // accept implies skid empty, so skid and a new beat never compete here
            if (skid_vld_q) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_d = in_ent;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (main_vld_q) begin
                skid_d     = in_ent;
                skid_vld_d = 1'b1;
            end else begin
                main_d     = in_ent;
                main_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end
`else
    assign in_ready = (~main_vld_q | out_ready) & ~redirect_q;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
        end else if (accept) begin
            main_d     = in_ent;
            main_vld_d = 1'b1;
        end else if (out_ready) begin
            main_vld_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q        <= '0;
            main_vld_q    <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            main_q        <= main_d;
            main_vld_q    <= main_vld_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign out_valid      = main_vld_q;
    assign out_result     = main_q.result;
    assign out_store_data = main_q.store_data;
    assign out_rd         = main_q.rd;
    assign out_rd_we      = main_q.rd_we;
    assign out_mem_rd     = main_q.mem_rd;
    assign out_mem_wr     = main_q.mem_wr;
    assign redirect       = redirect_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ex_result_stage.sv
// Randomized bench for ex_result_stage against a queue-based model; follows EX_SKID_BUF_EN if defined.
module tb_ex_result_stage;

`ifdef EX_SKID_BUF_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, alu_zero, alu_ofl, alu_cout;
    logic        br_en, jump, rd_we, mem_rd, mem_wr, flush, out_valid, out_ready;
    logic [2:0]  br_funct3;
    logic [31:0] alu_out, br_target, pc_plus4, store_data;
    logic [4:0]  rd;
    logic [31:0] out_result, out_store_data, redirect_pc;
    logic [4:0]  out_rd;
    logic        out_rd_we, out_mem_rd, out_mem_wr, redirect;

    logic [31:0] opa, opb;

    typedef struct {
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        we, mr, mw;
    } ent_t;

    ent_t        q[$];
    logic        m_redir;
    logic [31:0] m_pc;
    int          vectors = 0;
    int          errs    = 0;

    ex_result_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_ofl(alu_ofl), .alu_cout(alu_cout),
        .br_en(br_en), .jump(jump), .br_funct3(br_funct3), .br_target(br_target),
        .pc_plus4(pc_plus4), .rd(rd), .rd_we(rd_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .store_data(store_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store_data(out_store_data), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ALU behaviour for a branch compare: out = A - B, carry from A + ~B + 1
    task automatic set_alu();
        logic [32:0] s;
        s        = {1'b0, opa} + {1'b0, ~opb} + 33'd1;
        alu_out  = s[31:0];
        alu_cout = s[32];
        alu_zero = (s[31:0] == 32'd0);
        alu_ofl  = (opa[31] != opb[31]) && (s[31] != opa[31]);
    endtask

    function automatic bit ref_taken();
        bit c;
        case (br_funct3)
            3'd0:    c = (opa == opb);
            3'd1:    c = (opa != opb);
            3'd4:    c = ($signed(opa) <  $signed(opb));
            3'd5:    c = ($signed(opa) >= $signed(opb));
            3'd6:    c = (opa <  opb);
            3'd7:    c = (opa >= opb);
            default: c = 1'b0;
        endcase
        return jump || (br_en && c);
    endfunction

    task automatic clr();
        in_valid = 0; br_en = 0; jump = 0; flush = 0; out_ready = 1;
        br_funct3 = 0; rd_we = 0; mem_rd = 0; mem_wr = 0; rd = 0;
        opa = 0; opb = 0; br_target = 0; pc_plus4 = 0; store_data = 0;
        set_alu();
    endtask

    // Called just after a falling edge with inputs already applied
    task automatic step();
        bit   rdy, acc;
        ent_t e;
        #1;
        rdy = !m_redir && ((CAP == 2) ? (q.size() < 2) : (q.size() == 0 || out_ready));
        chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("out_result", out_result, q[0].res);
            chk("out_store_data", out_store_data, q[0].sd);
            chk("out_rd", {27'd0, out_rd}, {27'd0, q[0].rd});
            chk("out_flags", {29'd0, out_rd_we, out_mem_rd, out_mem_wr},
                {29'd0, q[0].we, q[0].mr, q[0].mw});
        end
        chk("redirect", {31'd0, redirect}, {31'd0, m_redir});
        if (m_redir) chk("redirect_pc", redirect_pc, m_pc);
        acc = in_valid && rdy;
        if (flush) begin
            q.delete();
            m_redir = 0;
        end else begin
            if (q.size() != 0 && out_ready) q.delete(0);
            if (acc) begin
                e.res = jump ? pc_plus4 : alu_out;
                e.sd  = store_data;
                e.rd  = rd;
                e.we  = (br_en && !jump) ? 1'b0 : rd_we;
                e.mr  = mem_rd;
                e.mw  = mem_wr;
                q.push_back(e);
            end
            m_redir = acc && ref_taken();
            m_pc    = br_target;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0; in_valid = 0;
        @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        q.delete();
        m_redir = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        m_redir = 0; m_pc = 0;
        clr();
        @(negedge clk);
        do_reset();

        // taken BEQ: redirect to 0x100, rd_we suppressed, wrong-path beat refused
        clr(); in_valid = 1; br_en = 1; br_funct3 = 3'd0; opa = 32'd7; opb = 32'd7;
        rd_we = 1; rd = 5'd3; br_target = 32'h100; set_alu(); step();
        clr(); in_valid = 1; rd_we = 1; rd = 5'd9; opa = 32'd1; set_alu(); step();
        chk("beq_out_rd_we", {31'd0, out_rd_we}, 32'd0);

        // BLT 0 < 0x8000_0000 signed is false (alu_out msb=1, ofl=1)
        clr(); in_valid = 1; br_en = 1; br_funct3 = 3'd4; opa = 32'd0; opb = 32'h8000_0000;
        br_target = 32'h200; set_alu(); step();
        // BLTU 1 < 2 taken (carry-out 0)
        clr(); in_valid = 1; br_en = 1; br_funct3 = 3'd6; opa = 32'd1; opb = 32'd2;
        br_target = 32'h300; set_alu(); step();
        clr(); step();

        // JAL links pc+4 into rd
        clr(); in_valid = 1; jump = 1; pc_plus4 = 32'h2004; rd = 5'd1; rd_we = 1;
        br_target = 32'h4000; step();
        clr(); step();
        clr(); step();

        // stall: ADD beats offered with out_ready low, then drain
        for (int i = 0; i < 3; i++) begin
            clr(); out_ready = 0; in_valid = 1; rd_we = 1; rd = 5'(i + 4);
            opa = 32'd100 + i; set_alu(); step();
        end
        for (int i = 0; i < 3; i++) begin
            clr(); step();
        end

        // flush beats accept of a taken branch
        clr(); in_valid = 1; br_en = 1; br_funct3 = 3'd0; br_target = 32'h500; flush = 1;
        set_alu(); step();
        clr(); step();

        // reset while a beat is held
        clr(); out_ready = 0; in_valid = 1; rd_we = 1; opa = 32'h55; set_alu(); step();
        out_ready = 0; in_valid = 0; do_reset();
        clr(); step();

        for (int n = 0; n < 1500; n++) begin
            in_valid   = ($urandom_range(0, 9) < 7);
            out_ready  = ($urandom_range(0, 9) < 7);
            flush      = ($urandom_range(0, 19) == 0);
            jump       = ($urandom_range(0, 9) == 0);
            br_en      = ($urandom_range(0, 9) < 3);
            br_funct3  = 3'($urandom);
            rd         = 5'($urandom);
            rd_we      = 1'($urandom);
            mem_rd     = 1'($urandom);
            mem_wr     = 1'($urandom);
            opa        = $urandom;
            case ($urandom_range(0, 3))
                0:       opb = opa;
                1:       opb = opa ^ 32'h8000_0000;
                default: opb = $urandom;
            endcase
            br_target  = $urandom;
            pc_plus4   = $urandom;
            store_data = $urandom;
            set_alu();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
